bcd_display_driver: RTL and testbench

//  Display end of the game controller's BCD_in/game_number outputs.

---
 rtl/bcd_display_driver.sv | 167 ++++++++++++++++
 tb/tb_bcd_display_driver.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bcd_display_driver.sv
// Sequential double-dabble converter driving four active-low 7-segment displays (s.cc plus game id).
// Optional display blinking is compiled in when the BLINK_EN macro is defined.
module bcd_display_driver #(
   parameter int unsigned BIN_W     = 10,
   parameter int unsigned BLINK_DIV = 12500000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [BIN_W-1:0] bin_in,
   input  logic [3:0]       game_number,
   input  logic             blink,
   output logic             busy,
   output logic             done,
   output logic [6:0]       hex0,
   output logic [6:0]       hex1,
   output logic [6:0]       hex2,
   output logic             hex2_dp,
   output logic [6:0]       hex3
);

   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, UPD} state_t;

   state_t           state;
   logic [BIN_W-1:0] last_bin;
   logic [BIN_W-1:0] val;
   logic [11:0]      bcd;
   logic [11:0]      bcd_adj;
   logic [CNT_W-1:0] cnt;
   logic             pending;
   logic [6:0]       dig0, dig1, dig2, gid;
   logic             dp;

   function automatic logic [6:0] seg_digit(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   function automatic logic [6:0] seg_game(input logic [3:0] g);
      logic [6:0] s;
      case (g)
         4'd0:    s = 7'h79;
         4'd1:    s = 7'h24;
         4'd2:    s = 7'h30;
         4'd3:    s = 7'h19;
         4'd4:    s = 7'h08;
         4'd5:    s = 7'h03;
         4'd6:    s = 7'h46;
         4'd7:    s = 7'h21;
         4'd8:    s = 7'h06;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // add-3 correction applied to every nibble before each shift
   always_comb begin
      bcd_adj = bcd;
      for (int unsigned i = 0; i < 3; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         last_bin <= '0;
         val      <= '0;
         bcd      <= '0;
         cnt      <= '0;
         pending  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         dig0     <= '1;
         dig1     <= '1;
         dig2     <= '1;
         dp       <= 1'b1;
         gid      <= '1;
      end else begin
         gid  <= seg_game(game_number);
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (pending || bin_in != last_bin) begin
                  val      <= (32'(bin_in) > 32'd999) ? BIN_W'(999) : bin_in;
                  last_bin <= bin_in;
                  bcd      <= '0;
                  cnt      <= '0;
                  pending  <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               bcd <= {bcd_adj[10:0], val[BIN_W-1]};
               val <= {val[BIN_W-2:0], 1'b0};
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(BIN_W - 1))
                  state <= UPD;
            end
            UPD: begin
               dig0  <= seg_digit(bcd[3:0]);
               dig1  <= seg_digit(bcd[7:4]);
               dig2  <= seg_digit(bcd[11:8]);
               dp    <= 1'b0;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BLINK_EN
   logic [31:0] blink_cnt;
   logic        phase;
   logic        blank_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
         blank_q   <= 1'b0;
      end else begin
         if (blink_cnt == 32'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 32'd1;
         end
         blank_q <= blink && phase;
      end
   end

   assign hex0    = blank_q ? 7'h7F : dig0;
   assign hex1    = blank_q ? 7'h7F : dig1;
   assign hex2    = blank_q ? 7'h7F : dig2;
   assign hex3    = blank_q ? 7'h7F : gid;
   assign hex2_dp = blank_q ? 1'b1  : dp;
`else
   logic blink_unused;
   assign blink_unused = blink;

   assign hex0    = dig0;
   assign hex1    = dig1;
   assign hex2    = dig2;
   assign hex3    = gid;
   assign hex2_dp = dp;
`endif

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed self-checking bench for bcd_display_driver: conversion latency, digits, clamping,
// mid-conversion input changes, game id decode and reset abort.
module tb_bcd_display_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] bin_in;
   logic [3:0] game_number;
   logic       blink;
   logic       busy, done, hex2_dp;
   logic [6:0] hex0, hex1, hex2, hex3;

   int checks = 0;
   int errors = 0;

   bcd_display_driver #(.BIN_W(10), .BLINK_DIV(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .bin_in      (bin_in),
      .game_number (game_number),
      .blink       (blink),
      .busy        (busy),
      .done        (done),
      .hex0        (hex0),
      .hex1        (hex1),
      .hex2        (hex2),
      .hex2_dp     (hex2_dp),
      .hex3        (hex3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Steps negedge by negedge until done is seen or the budget runs out.
   task automatic wait_done(output int edges, output int busy_n);
      edges  = 0;
      busy_n = 0;
      while (edges < 40) begin
         @(negedge clk);
         edges++;
         if (done) break;
         if (busy) busy_n++;
      end
   endtask

   task automatic run_conv(input string tag, input logic [6:0] e2, input logic [6:0] e1,
                           input logic [6:0] e0);
      int edges, busy_n;
      wait_done(edges, busy_n);
      check({tag, "_done"},    16'(done), 16'd1);
      check({tag, "_latency"}, 16'(edges), 16'd12);
      check({tag, "_busy_n"},  16'(busy_n), 16'd11);
      check({tag, "_hex2"},    16'(hex2), 16'(e2));
      check({tag, "_hex1"},    16'(hex1), 16'(e1));
      check({tag, "_hex0"},    16'(hex0), 16'(e0));
      check({tag, "_dp"},      16'(hex2_dp), 16'd0);
      check({tag, "_busy"},    16'(busy), 16'd0);
      @(negedge clk);
      check({tag, "_pulse"},   16'(done), 16'd0);
   endtask

   logic [6:0] gtab [10];

   initial begin
      int edges, busy_n;
      gtab = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};

      reset = 1'b1; bin_in = 10'd0; game_number = 4'd0; blink = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_hex0", 16'(hex0), 16'h7F);
      check("rst_hex1", 16'(hex1), 16'h7F);
      check("rst_hex2", 16'(hex2), 16'h7F);
      check("rst_hex3", 16'(hex3), 16'h7F);
      check("rst_dp",   16'(hex2_dp), 16'd1);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_done", 16'(done), 16'd0);

      // first value after reset converts even though it equals last_bin
      reset = 1'b0;
      run_conv("zero", 7'h40, 7'h40, 7'h40);
      check("zero_hex3", 16'(hex3), 16'h79);
      repeat (3) @(negedge clk);
      check("idle_busy", 16'(busy), 16'd0);

      bin_in = 10'd537;
      run_conv("v537", 7'h12, 7'h30, 7'h78);

      bin_in = 10'd1023;
      run_conv("v1023", 7'h10, 7'h10, 7'h10);
      bin_in = 10'd999;
      run_conv("v999", 7'h10, 7'h10, 7'h10);

      // change input two cycles into a conversion
      bin_in = 10'd100;
      repeat (2) @(negedge clk);
      bin_in = 10'd250;
      wait_done(edges, busy_n);
      check("v100_done",    16'(done), 16'd1);
      check("v100_latency", 16'(edges + 2), 16'd12);
      check("v100_hex2",    16'(hex2), 16'h79);
      check("v100_hex1",    16'(hex1), 16'h40);
      check("v100_hex0",    16'(hex0), 16'h40);
      run_conv("v250", 7'h24, 7'h12, 7'h40);

      for (int g = 0; g < 10; g++) begin
         game_number = 4'(g);
         @(negedge clk);
         check($sformatf("gid%0d", g), 16'(hex3), 16'(gtab[g]));
      end
      game_number = 4'd2;

      // reset in the middle of the shift phase
      bin_in = 10'd321;
      repeat (4) @(negedge clk);
      check("mid_busy", 16'(busy), 16'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_hex0", 16'(hex0), 16'h7F);
      check("abort_hex1", 16'(hex1), 16'h7F);
      check("abort_hex2", 16'(hex2), 16'h7F);
      check("abort_hex3", 16'(hex3), 16'h7F);
      check("abort_dp",   16'(hex2_dp), 16'd1);
      check("abort_busy", 16'(busy), 16'd0);
      reset = 1'b0;
      run_conv("v321", 7'h30, 7'h24, 7'h79);

`ifdef BLINK_EN
      begin
         int blanks = 0;
         blink = 1'b1;
         repeat (2) @(negedge clk);
         for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (hex0 == 7'h7F && hex3 == 7'h7F && hex2_dp) blanks++;
         end
         check("blink_blanks", 16'(blanks), 16'd8);
         blink = 1'b0;
         repeat (2) @(negedge clk);
         check("blink_off_hex0", 16'(hex0), 16'h79);
      end
`else
      blink = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("noblink%0d", i), 16'(hex0), 16'h79);
      end
      blink = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
